// File: rtl/mem_access_master_if.sv
// mem_access_master_if: client request, write-data, read-data and
// memory-side signals of the burst memory master.
interface mem_access_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [3:0]  req_addr;
  logic [3:0]  req_len;
  logic        wd_valid;
  logic        wd_ready;
  logic [15:0] wd_data;
  logic        rd_valid;
  logic        rd_last;
  logic [15:0] rd_data;
  logic        done;
  logic        err;
  logic [3:0]  err_addr;
  logic        MEMR;
  logic        MEMW;
  logic [3:0]  ADDR;
  logic [15:0] WDATA;
  logic [15:0] MRDATA;

  modport master (
    input  req_valid, req_wr, req_addr, req_len,
    input  wd_valid, wd_data, MRDATA,
    output req_ready, wd_ready, rd_valid, rd_last,
    output rd_data, done, err, err_addr,
    output MEMR, MEMW, ADDR, WDATA
  );

  modport slave (
    output req_valid, req_wr, req_addr, req_len,
    output wd_valid, wd_data, MRDATA,
    input  req_ready, wd_ready, rd_valid, rd_last,
    input  rd_data, done, err, err_addr,
    input  MEMR, MEMW, ADDR, WDATA
  );
endinterface

// File: rtl/mem_access_master.sv
// mem_access_master: 1..16 beat read/write bursts to a 16-word memory.
// Define MEM_MASTER_WRITE_VERIFY_EN to read back and check each write.
module mem_access_master (
  input logic CLK,
  input logic RST,
  mem_access_master_if.master bus
);
  typedef enum logic [2:0] {
    IDLE, RD_BURST, RD_DRAIN, WR_BURST, WR_VERIFY, DONE
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  ptr_q, ptr_d;
  logic [3:0]  addr_q, addr_d;
  logic        more_q, more_d;
  logic        memr_q, memr_d;
  logic        memw_q, memw_d;
  logic [15:0] wdata_q, wdata_d;
  logic        rdp_q, rdp_d;
  logic        rd_valid_q, rd_valid_d;
  logic        rd_last_q, rd_last_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic        done_q, done_d;
  logic        wd_ready_q, wd_ready_d;
  logic        wr_hs;
`ifdef MEM_MASTER_WRITE_VERIFY_EN
  logic        chk_q, chk_d;
  logic        err_q, err_d;
  logic [3:0]  err_addr_q, err_addr_d;
`endif

  assign wr_hs = bus.wd_valid & wd_ready_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    addr_d     = addr_q;
    more_d     = more_q;
    wdata_d    = wdata_q;
    memr_d     = 1'b0;
    memw_d     = 1'b0;
    rdp_d      = 1'b0;
    rd_last_d  = 1'b0;
    done_d     = 1'b0;
    wd_ready_d = 1'b0;
    // rdp marks the cycle in which MRDATA of a read beat is valid
    rd_valid_d = rdp_q;
    rd_data_d  = rdp_q ? bus.MRDATA : rd_data_q;
`ifdef MEM_MASTER_WRITE_VERIFY_EN
    chk_d      = 1'b0;
    err_d      = err_q;
    err_addr_d = err_addr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          cnt_d = bus.req_len;
          if (bus.req_wr) begin
            ptr_d      = bus.req_addr;
            more_d     = 1'b1;
            wd_ready_d = 1'b1;
            state_d    = WR_BURST;
          end else begin
            memr_d  = 1'b1;
            addr_d  = bus.req_addr;
            state_d = RD_BURST;
          end
        end
      end
      RD_BURST: begin
        rdp_d = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = RD_DRAIN;
        end else begin
          memr_d = 1'b1;
          addr_d = addr_q + 4'd1;
          cnt_d  = cnt_q - 4'd1;
        end
      end
      RD_DRAIN: begin
        rd_last_d = 1'b1;
        done_d    = 1'b1;
        state_d   = DONE;
      end
      WR_BURST: begin
`ifdef MEM_MASTER_WRITE_VERIFY_EN
        if (chk_q && !err_q && (bus.MRDATA != wdata_q)) begin
          err_d      = 1'b1;
          err_addr_d = addr_q;
        end
        if (memw_q) begin
          memr_d  = 1'b1;
          state_d = WR_VERIFY;
        end else
`endif
        if (wr_hs) begin
          memw_d  = 1'b1;
          addr_d  = ptr_q;
          wdata_d = bus.wd_data;
          ptr_d   = ptr_q + 4'd1;
          cnt_d   = cnt_q - 4'd1;
          more_d  = (cnt_q != 4'd0);
`ifdef MEM_MASTER_WRITE_VERIFY_EN
          wd_ready_d = 1'b0;
`else
          wd_ready_d = (cnt_q != 4'd0);
`endif
        end else if (more_q) begin
          wd_ready_d = 1'b1;
        end else begin
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      WR_VERIFY: begin
`ifdef MEM_MASTER_WRITE_VERIFY_EN
        chk_d      = 1'b1;
        wd_ready_d = more_q;
        state_d    = WR_BURST;
`else
        state_d = IDLE;
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ptr_q      <= '0;
      addr_q     <= '0;
      more_q     <= 1'b0;
      memr_q     <= 1'b0;
      memw_q     <= 1'b0;
      wdata_q    <= '0;
      rdp_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= '0;
      done_q     <= 1'b0;
      wd_ready_q <= 1'b0;
`ifdef MEM_MASTER_WRITE_VERIFY_EN
      chk_q      <= 1'b0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      addr_q     <= addr_d;
      more_q     <= more_d;
      memr_q     <= memr_d;
      memw_q     <= memw_d;
      wdata_q    <= wdata_d;
      rdp_q      <= rdp_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      rd_data_q  <= rd_data_d;
      done_q     <= done_d;
      wd_ready_q <= wd_ready_d;
`ifdef MEM_MASTER_WRITE_VERIFY_EN
      chk_q      <= chk_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
`endif
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.wd_ready  = wd_ready_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_last   = rd_last_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.done      = done_q;
  assign bus.MEMR      = memr_q;
  assign bus.MEMW      = memw_q;
  assign bus.ADDR      = addr_q;
  assign bus.WDATA     = wdata_q;
`ifdef MEM_MASTER_WRITE_VERIFY_EN
  assign bus.err       = err_q;
  assign bus.err_addr  = err_addr_q;
`else
  assign bus.err       = 1'b0;
  assign bus.err_addr  = 4'd0;
`endif
endmodule

// File: doc/mem_access_master.md
MEM_ACCESS_MASTER -- requirements
Module: mem_access_master

Interface
REQ-001 SHALL: CLK  in  1  clock; all state changes on the rising edge.
REQ-002 SHALL: RST  in  1  asynchronous, active-high reset.
REQ-003 SHALL: req_valid  in  1  client request valid.
REQ-004 SHALL: req_ready  out  1  high iff the FSM is in IDLE.
REQ-005 SHALL: req_wr  in  1  1 = write burst, 0 = read burst.
REQ-006 SHALL: req_addr  in  4  burst start address.
REQ-007 SHALL: req_len  in  4  beats minus 1 (0..15 gives 1..16 beats).
REQ-008 SHALL: wd_valid / wd_ready  in / out  1 / 1  write-data handshake.
REQ-009 SHALL: wd_data  in  16  write beat data.
REQ-010 SHALL: rd_valid, rd_last  out  1, 1  read beat pulse and final-beat flag; no backpressure.
REQ-011 SHALL: rd_data  out  16  read beat data.
REQ-012 SHALL: done  out  1  one-cycle pulse when a burst completes.
REQ-013 SHALL: MEMR, MEMW  out  1, 1  registered memory read and write strobes; never high in the same cycle.
REQ-014 SHALL: ADDR  out  4  registered memory address.
REQ-015 SHALL: WDATA  out  16  registered memory write data.
REQ-016 SHALL: MRDATA  in  16  memory read data, valid the cycle after the MEMR cycle.

Function
REQ-017 SHALL: FSM states are IDLE, RD_BURST, RD_DRAIN, WR_BURST, WR_VERIFY, DONE.
REQ-018 SHALL: a request is accepted on the edge where req_valid and req_ready are both high; addr, len and op are latched and the beat counter is loaded with len.
REQ-019 SHALL: for a read burst, MEMR is high for exactly len+1 consecutive cycles starting the cycle after acceptance.
- ADDR starts at req_addr and increments by 1 per cycle, wrapping 15 to 0.
REQ-020 SHALL: MRDATA is sampled at the end of the cycle following each MEMR cycle.
- rd_valid and rd_data are registered, so each beat appears 2 cycles after its MEMR cycle.
- An N-beat read gives rd_valid in cycles 3..N+2 relative to acceptance at cycle 0.
REQ-021 SHALL: rd_last and done are both high in the same cycle as the final rd_valid.
- FSM returns to IDLE; req_ready is high in the next cycle.
REQ-022 SHALL: for a write burst, wd_ready is high in WR_BURST while beats remain.
- Each wd_valid & wd_ready edge registers MEMW=1, ADDR=current address and WDATA=wd_data for exactly the next cycle.
- Back-to-back beats run at 1 per cycle when verify is compiled out.
REQ-023 SHALL: when wd_valid is low, MEMW is 0 the next cycle and the address does not advance.
REQ-024 SHALL: done pulses in the cycle after the final MEMW cycle (or after the final verify compare), then the FSM returns to IDLE.
REQ-025 SHALL: ADDR and WDATA hold their last values when MEMR and MEMW are both 0.
REQ-026 SHALL: wd_valid outside a write burst has no effect, and wd_ready stays 0.
REQ-027 SHALL: req_valid while busy has no effect; the request is held off by req_ready=0.
REQ-028 SHALL: bursts longer than 16 beats cannot occur; a 16-beat burst from any start address touches every address exactly once.

Reset
REQ-029 SHALL: RST forces IDLE and drives the following to 0: MEMR, MEMW, ADDR, WDATA, rd_valid, rd_last, rd_data, done, wd_ready, err, err_addr. req_ready is 1 after release.
REQ-030 SHALL: reset during a burst abandons it; no done pulse and no further memory strobes occur.

Configuration
REQ-031 SHALL: with macro MEM_MASTER_WRITE_VERIFY_EN defined, each write beat is followed by a read-back of the same address.
- Cycle sequence: MEMW cycle, then MEMR cycle (WR_VERIFY), then MRDATA compared to the written data one cycle later.
- wd_ready is low during verify, so the rate is 1 beat per 3 cycles.
REQ-032 SHALL: with the macro defined, any mismatch sets err (sticky until reset) and err_addr (4-bit output, first failing address only).
- A failed compare does not stop the burst.
REQ-033 SHALL: with the macro undefined, err and err_addr are constant 0 and WR_VERIFY is unreachable.

Verification
REQ-034 SHALL: write 4 beats from addr 0xE, data 0x1111..0x4444, wd_valid held high -> MEMW in 4 consecutive cycles at ADDR E,F,0,1; done 1 cycle after the last MEMW (verify off).
REQ-035 SHALL: read 4 beats from 0xE after REQ-034 -> MEMR in cycles 1-4; rd_data 0x1111,0x2222,0x3333,0x4444 in cycles 3-6; rd_last and done in cycle 6; req_ready high in cycle 7.
REQ-036 SHALL: write 3 beats with wd_valid low for 2 cycles between beats -> MEMW cycles separated by gaps, ADDR increments exactly 3 times, single done.
REQ-037 SHALL: RST asserted during cycle 3 of a 16-beat read -> all outputs 0 immediately, no done, req_ready=1 after release, new request accepted.
REQ-038 SHALL: verify on, memory model corrupts address 5 -> err=1, err_addr=5, burst completes with done, err stays high until RST.
REQ-039 SHALL: req_len=0 single read of addr 0xF -> one MEMR cycle, one rd_valid with rd_last=1 and done in cycle 3.
